// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte buffer between the UART register logic and the
// UART bit sender. Bytes written by the CPU are queued in a FIFO. A small
// launcher hands them to the sender one at a time: a one-cycle tx_en pulse,
// with tx_data held for the whole frame. The launcher then waits for the
// sender status to go busy and back to idle before it launches the next byte.
//
// Ports:
//   CLK, Reset_n      clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data    push one byte per cycle
//   clr_ovf           clears the sticky overflow flag (and tx_done_irq)
//   full, empty       FIFO occupancy flags
//   level             entry count, 0..2**ADDR_W
//   overflow          sticky: a push was attempted while full
//   busy              launcher active or FIFO non-empty
//   tx_data, tx_en    byte and launch pulse to the sender (registered)
//   tx_status         sender status, 1 = idle, 0 = frame in progress
//   tx_done_irq       only with UART_TXFIFO_IRQ_EN: last queued frame done
//
// Optional feature macro: UART_TXFIFO_IRQ_EN adds the tx_done_irq output.

module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_status
`ifdef UART_TXFIFO_IRQ_EN
    ,
    output logic              tx_done_irq
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              pop;
    logic              push;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign level = count;
    assign busy  = (state != IDLE) || !empty;

    // Pop only on the IDLE -> LAUNCH step. A pop frees a slot on the same
    // edge, so a push arriving while full is still accepted in that cycle.
    assign pop  = (state == IDLE) && !empty && tx_status;
    assign push = wr_en && (!full || pop);

    // Storage is not reset; only the pointers and the count define contents.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Setting has priority over clearing.
            if (wr_en && !push) overflow <= 1'b1;
            else if (clr_ovf)   overflow <= 1'b0;
        end
    end

    // Launcher: tx_en and tx_data are registered; tx_data changes only on a
    // pop and is otherwise held, including while idle.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_en   <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                // Status is ignored for one cycle, giving the sender time to
                // react to tx_en before its status is trusted.
                LAUNCH:     state <= WAIT_START;
                WAIT_START: if (!tx_status) state <= WAIT_DONE;
                WAIT_DONE:  if (tx_status)  state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXFIFO_IRQ_EN
    // Fires when a frame completes with nothing left to send.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_done_irq <= 1'b0;
        end else if ((state == WAIT_DONE) && tx_status && empty) begin
            tx_done_irq <= 1'b1;
        end else if (push || clr_ovf) begin
            tx_done_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. A queue-based reference model predicts every
// launch, the byte order, the occupancy flags and the sticky flags. A sender
// model drives tx_status in reaction to tx_en. The bench runs directed
// sequences, a table of vectors for fill/overflow and a long randomized run.

module tb_uart_tx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_ovf = 1'b0;
    logic          tx_status = 1'b1;
    logic          full, empty, overflow, busy, tx_en;
    logic [AW:0]   level;
    logic [7:0]    tx_data;
`ifdef UART_TXFIFO_IRQ_EN
    logic          tx_done_irq;
`endif

    uart_tx_fifo #(.ADDR_W(AW)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .busy(busy), .tx_data(tx_data), .tx_en(tx_en),
        .tx_status(tx_status)
`ifdef UART_TXFIFO_IRQ_EN
        , .tx_done_irq(tx_done_irq)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: queued bytes, launcher readiness, sticky flags.
    // wait_ph counts what the launcher still needs before it may launch
    // again: 3 = launch cycle, 2 = needs status low, 1 = needs status high.
    logic [7:0] q[$];
    int         wait_ph;
    bit         m_ovf;
    bit         m_irq;
    logic [7:0] m_data;
    int         pulses;
    logic [7:0] last_tx;
    int         irq_pulses;   // pulse count when tx_done_irq was first seen high

    // Sender model: after a launch, status drops after a delay and stays
    // low for a random frame length.
    bit auto_snd;
    int cyc, drop_at, rise_at;
    int dly_lo, dly_hi, len_lo, len_hi;

    task automatic model_reset();
        q.delete();
        wait_ph = 0; m_ovf = 0; m_irq = 0; m_data = 8'h00;
        drop_at = 0; rise_at = 0; irq_pulses = -1;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic c);
        logic st;
        bit   exp_pop, acc, irq_set, empty_pre;
        wr_en = w; wr_data = d; clr_ovf = c;
        if (auto_snd) tx_status = !((cyc + 1) >= drop_at && (cyc + 1) < rise_at);
        st = tx_status;
        @(posedge CLK);
        #1;
        cyc++;
        empty_pre = (q.size() == 0);
        exp_pop   = (wait_ph == 0) && !empty_pre && st;
        irq_set   = 0;
        chk("tx_en", int'(tx_en), int'(exp_pop));
        if (exp_pop) begin
            m_data  = q.pop_front();
            wait_ph = 3;
        end else if (wait_ph == 3) wait_ph = 2;
        else if (wait_ph == 2 && !st) wait_ph = 1;
        else if (wait_ph == 1 && st) begin
            wait_ph = 0;
            irq_set = empty_pre;
        end
        acc = w && (q.size() < DEPTH);
        if (acc) q.push_back(d);
        if (w && !acc) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (irq_set) m_irq = 1;
        else if (acc || c) m_irq = 0;
        chk("tx_data", int'(tx_data), int'(m_data));
        chk("level", int'(level), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'(wait_ph != 0 || q.size() != 0));
`ifdef UART_TXFIFO_IRQ_EN
        chk("tx_done_irq", int'(tx_done_irq), int'(m_irq));
        if (tx_done_irq && irq_pulses < 0) irq_pulses = pulses;
`endif
        if (tx_en) begin
            pulses++;
            last_tx = tx_data;
            drop_at = cyc + 1 + int'($urandom_range(dly_hi, dly_lo));
            rise_at = drop_at + int'($urandom_range(len_hi, len_lo));
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((wait_ph != 0 || q.size() != 0) && n < budget) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 0, 1);
    endtask

    // Reset applied between edges; outputs must clear without a clock.
    task automatic apply_reset(input bit check);
        Reset_n = 1'b0;
        wr_en = 1'b0; clr_ovf = 1'b0; tx_status = 1'b1;
        #2;
        if (check) begin
            chk("rst_level", int'(level), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_full", int'(full), 0);
            chk("rst_tx_en", int'(tx_en), 0);
            chk("rst_tx_data", int'(tx_data), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_busy", int'(busy), 0);
`ifdef UART_TXFIFO_IRQ_EN
            chk("rst_irq", int'(tx_done_irq), 0);
`endif
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       clr;
        logic       st;
        int         lvl;
        logic       full;
        logic       ovf;
        logic       ten;
    } vec_t;

    vec_t tbl[19];
    int   p0;

    initial begin
        // Table: fill with sender busy, overflow on the 17th push, clear
        // overflow, then let one byte launch.
        for (int i = 0; i < 17; i++)
            tbl[i] = '{1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0,
                       (i < 16) ? i + 1 : 16, i >= 15, i >= 16, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1};

        cyc = 0; pulses = 0; last_tx = 8'h00;
        dly_lo = 0; dly_hi = 2; len_lo = 2; len_hi = 6;
        auto_snd = 1;
        #3;
        apply_reset(1'b1);

        // Mid-frame reset with five bytes still queued.
        dly_lo = 0; dly_hi = 0; len_lo = 120; len_hi = 120;
        for (int i = 0; i < 6; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("pre_rst_level", int'(level), 5);
        apply_reset(1'b1);

        // Single byte with a long frame.
        dly_lo = 1; dly_hi = 1;
        p0 = pulses;
        step(1'b1, 8'hA5, 1'b0);
        drain(400);
        chk("single_pulses", pulses - p0, 1);
        chk("single_data", int'(tx_data), 8'hA5);
        chk("single_busy", int'(busy), 0);

        // Burst of 16 consecutive pushes.
        dly_lo = 0; dly_hi = 2; len_lo = 2; len_hi = 6;
        p0 = pulses;
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        drain(1000);
        chk("burst_pulses", pulses - p0, 16);
        chk("burst_last", int'(last_tx), 8'h10);

        // Fill / overflow / clear table with the sender status held low.
        apply_reset(1'b0);
        auto_snd = 0;
        p0 = pulses;
        for (int i = 0; i < 19; i++) begin
            tx_status = tbl[i].st;
            step(tbl[i].wr, tbl[i].d, tbl[i].clr);
            chk("tbl_level", int'(level), tbl[i].lvl);
            chk("tbl_full", int'(full), int'(tbl[i].full));
            chk("tbl_ovf", int'(overflow), int'(tbl[i].ovf));
            chk("tbl_tx_en", int'(tx_en), int'(tbl[i].ten));
        end
        auto_snd = 1;
        drain(1000);
        chk("ovf_sent", pulses - p0, 16);
        chk("ovf_last", int'(last_tx), 8'hBF);

        // Push into the pop cycle while full.
        apply_reset(1'b0);
        auto_snd = 0;
        tx_status = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        tx_status = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        chk("simul_level", int'(level), 16);
        chk("simul_ovf", int'(overflow), 0);
        chk("simul_tx_en", int'(tx_en), 1);
        auto_snd = 1;
        drain(1000);
        chk("simul_last", int'(last_tx), 8'h77);

`ifdef UART_TXFIFO_IRQ_EN
        // Done interrupt after the second of two frames, cleared by a push.
        apply_reset(1'b0);
        p0 = pulses;
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        drain(200);
        chk("irq_after_2nd", irq_pulses - p0, 2);
        chk("irq_set", int'(tx_done_irq), 1);
        step(1'b1, 8'hC3, 1'b0);
        chk("irq_clr_push", int'(tx_done_irq), 0);
        drain(200);
`endif

        // Randomized traffic against the model.
        apply_reset(1'b0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) < 45, 8'($urandom), $urandom_range(99) < 4);
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
